// File: rtl/dot_product_pkg.sv
// Shared types and default sizes for the dot-product controller.
// DOT_PRODUCT_CTRL_PIPE_EN adds the DRAIN state used by the pipelined build.
package dot_product_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefMaxn  = 16;

`ifdef DOT_PRODUCT_CTRL_PIPE_EN
    typedef enum logic [1:0] {StIdle, StAccum, StOut, StDrain} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;
`endif

endpackage

// File: rtl/mul_add_unit.sv
// Combinational datapath: signed a*x, base+addend at ACC_W bits, and the
// shift-and-saturate view of base (the accumulator) for the narrow result.
module mul_add_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 36,
    parameter int unsigned SHIFT = 0
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [ACC_W-1:0] prod,
    input  logic signed [ACC_W-1:0] base,
    input  logic signed [ACC_W-1:0] addend,
    output logic signed [ACC_W-1:0] sum,
    output logic signed [WIDTH-1:0] y_sat,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        a_ext = {{(ACC_W-WIDTH){a[WIDTH-1]}}, a};
        x_ext = {{(ACC_W-WIDTH){x[WIDTH-1]}}, x};
        // Low ACC_W bits of the product are exact: |a*x| fits in 2*WIDTH bits.
        prod  = a_ext * x_ext;
        sum   = base + addend;

        shifted = base >>> SHIFT;
        if (shifted > SatMax) begin
            y_sat = SatMax[WIDTH-1:0];
            sat   = 1'b1;
        end else if (shifted < SatMin) begin
            y_sat = SatMin[WIDTH-1:0];
            sat   = 1'b1;
        end else begin
            y_sat = shifted[WIDTH-1:0];
            sat   = 1'b0;
        end
    end

endmodule

// File: rtl/dot_product_ctrl.sv
// Streaming dot-product controller: bias + sum(a*x) over len pairs, then a held result.
// DOT_PRODUCT_CTRL_PIPE_EN registers the product and inserts a one-cycle DRAIN state.
module dot_product_ctrl
    import dot_product_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned MAXN  = DefMaxn,
    parameter int unsigned SHIFT = 0,
    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(MAXN),
    localparam int unsigned CNT_W = $clog2(MAXN) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        len_i,
    input  logic signed [ACC_W-1:0] bias_i,
    output logic                    busy_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] x_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [ACC_W-1:0] y_ori_o,
    output logic signed [WIDTH-1:0] y_sat_o,
    output logic                    sat_o
);

    state_e state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_clip;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum;
    logic                    hs;
    logic                    last;
    logic                    acc_upd;

    assign hs       = in_valid_i & in_ready_o;
    assign last     = hs && (cnt_q == CNT_W'(1));
    assign len_clip = (len_i > CNT_W'(MAXN)) ? CNT_W'(MAXN) : len_i;

    mul_add_unit #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_mul_add (
        .a      (a_i),
        .x      (x_i),
        .prod   (prod),
        .base   (acc_q),
        .addend (addend),
        .sum    (sum),
        .y_sat  (y_sat_o),
        .sat    (sat_o)
    );

`ifdef DOT_PRODUCT_CTRL_PIPE_EN
    logic signed [ACC_W-1:0] prod_q;
    logic                    prod_vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            prod_vld_q <= hs;
            if (hs) begin
                prod_q <= prod;
            end
        end
    end

    // Accumulate one cycle behind the handshake that produced the product.
    assign addend  = prod_q;
    assign acc_upd = prod_vld_q;
`else
    assign addend  = prod;
    assign acc_upd = hs;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (len_clip != '0) ? StAccum : StOut;
                end
            end
            StAccum: begin
                if (last) begin
`ifdef DOT_PRODUCT_CTRL_PIPE_EN
                    state_d = StDrain;
`else
                    state_d = StOut;
`endif
                end
            end
`ifdef DOT_PRODUCT_CTRL_PIPE_EN
            StDrain: state_d = StOut;
`endif
            StOut: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != StIdle);
        in_ready_o  = (state_q == StAccum);
        out_valid_o = (state_q == StOut);
    end

    assign y_ori_o = acc_q;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if ((state_q == StIdle) && start_i) begin
            acc_d = bias_i;
            cnt_d = len_clip;
        end else begin
            if (acc_upd) begin
                acc_d = sum;
            end
            if (hs) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Scoreboard bench for dot_product_ctrl: jobs push expected results, a monitor pops on
// each output handshake. Honours DOT_PRODUCT_CTRL_PIPE_EN for the extra DRAIN cycle.
module tb_dot_product_ctrl;

    localparam int unsigned W     = 16;
    localparam int unsigned MAXN  = 16;
    localparam int unsigned ACC_W = 2 * W + $clog2(MAXN);
    localparam int unsigned CNT_W = $clog2(MAXN) + 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [CNT_W-1:0]        len;
    logic signed [ACC_W-1:0] bias;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     a;
    logic signed [W-1:0]     x;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] y_ori;
    logic signed [W-1:0]     y_sat;
    logic                    sat;

    typedef struct {
        longint ori;
        longint ysat;
        bit     sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dot_product_ctrl #(
        .WIDTH (W),
        .MAXN  (MAXN),
        .SHIFT (0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .len_i       (len),
        .bias_i      (bias),
        .busy_o      (busy),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .x_i         (x),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_ori_o     (y_ori),
        .y_sat_o     (y_sat),
        .sat_o       (sat)
    );

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got y_ori=%0d expected no output", y_ori);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_y_ori", y_ori, e.ori);
                check("sb_y_sat", y_sat, e.ysat);
                check("sb_sat", sat, e.sat);
            end
        end
    end

    task automatic start_job(input int l, input longint b, input bit expect_out,
                             input longint e_ori, input longint e_ysat, input bit e_sat);
        exp_t e;
        if (expect_out) begin
            e.ori  = e_ori;
            e.ysat = e_ysat;
            e.sat  = e_sat;
            sb.push_back(e);
        end
        start = 1'b1;
        len   = CNT_W'(l);
        bias  = ACC_W'(b);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_pair(input int av, input int xv);
        int n = 0;
        in_valid = 1'b1;
        a        = W'(av);
        x        = W'(xv);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("out_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_sat"}, sat, 0);
        check({tag, "_y_ori"}, y_ori, 0);
        check({tag, "_y_sat"}, y_sat, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        a         = '0;
        x         = '0;
        out_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back pairs and result latency.
        start_job(3, 0, 1'b1, -7, -7, 1'b0);
        push_pair(2, 3);
        push_pair(-4, 5);
        push_pair(7, 1);
        @(negedge clk);
`ifdef DOT_PRODUCT_CTRL_PIPE_EN
        check("lat_drain_no_valid", out_valid, 0);
        @(negedge clk);
`endif
        check("lat_out_valid", out_valid, 1);
        wait_out();

        // Saturation at both rails.
        start_job(2, 0, 1'b1, 2147352578, 32767, 1'b1);
        push_pair(32767, 32767);
        push_pair(32767, 32767);
        wait_out();
        start_job(1, 0, 1'b1, -1073709056, -32768, 1'b1);
        push_pair(-32768, 32767);
        wait_out();

        // Zero-length job goes straight to OUT with the bias.
        start_job(0, 100, 1'b1, 100, 100, 1'b0);
        @(negedge clk);
        check("len0_out_valid", out_valid, 1);
        check("len0_no_ready", in_ready, 0);
        wait_out();

        // Bubbles with junk operands must not accumulate.
        start_job(4, 5, 1'b1, -67, -67, 1'b0);
        push_pair(1, 2);
        a = W'(1000); x = W'(1000); @(posedge clk); #1;
        push_pair(3, 4);
        a = W'(1000); x = W'(1000); @(posedge clk); #1;
        push_pair(-5, 6);
        a = W'(1000); x = W'(1000); @(posedge clk); #1;
        push_pair(7, -8);
        wait_out();

        // Length above MAXN is clamped.
        start_job(20, 0, 1'b1, 16, 16, 1'b0);
        for (int i = 0; i < 16; i++) push_pair(1, 1);
        @(negedge clk);
        check("clamp_no_more_ready", in_ready, 0);
        wait_out();

        // Back-pressure: result held, start ignored.
        out_ready = 1'b0;
        start_job(1, 0, 1'b1, -100, -100, 1'b0);
        push_pair(10, -10);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            len   = CNT_W'(2);
            bias  = ACC_W'(999);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_busy", busy, 1);
            check("hold_y_ori", y_ori, -100);
            check("hold_y_sat", y_sat, -100);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_y_ori_held", y_ori, -100);
        check("idle_y_sat_held", y_sat, -100);
        @(negedge clk);
        check("start_in_out_ignored", busy, 0);
        @(posedge clk);
        #1;

        // Reset mid-job discards the partial result.
        start_job(4, 0, 1'b0, 0, 0, 1'b0);
        push_pair(1, 1);
        push_pair(2, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_job(1, 0, 1'b1, 9, 9, 1'b0);
        push_pair(3, 3);
        wait_out();

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_ctrl.md
DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed operand width.
REQ-002 SHALL have parameter MAXN, default 16, maximum vector length.
REQ-003 SHALL have parameter SHIFT, default 0, arithmetic right shift applied before saturation.
REQ-004 SHALL define ACC_W = 2*WIDTH + $clog2(MAXN), which is 36 at defaults.
REQ-005 SHALL have clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have start_i  input  1  start-job strobe, sampled in IDLE only.
REQ-008 SHALL have len_i  input  $clog2(MAXN)+1  vector length, sampled with start_i.
REQ-009 SHALL have bias_i  input  ACC_W signed  accumulator initial value, sampled with start_i.
REQ-010 SHALL have busy_o  output  1  high when not IDLE.
REQ-011 SHALL have in_valid_i / in_ready_o  input / output  1 each  operand handshake.
REQ-012 SHALL have a_i, x_i  input  WIDTH signed each  operand pair.
REQ-013 SHALL have out_valid_o / out_ready_i  output / input  1 each  result handshake.
REQ-014 SHALL have y_ori_o  output  ACC_W signed  full-precision result.
REQ-015 SHALL have y_sat_o  output  WIDTH signed  shifted and saturated result.
REQ-016 SHALL have sat_o  output  1  high when y_sat_o was clamped.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DRAIN and OUT; DRAIN SHALL exist only under REQ-033.
REQ-018 In IDLE with start_i=1: acc<=bias_i and cnt<=min(len_i,MAXN); next state SHALL be ACCUM if cnt>0, else OUT.
REQ-019 start_i SHALL be ignored outside IDLE.
REQ-020 in_ready_o SHALL be 1 only in ACCUM.
REQ-021 Each handshake (in_valid_i & in_ready_o) SHALL do acc<=acc+a_i*x_i and cnt<=cnt-1; cycles without a handshake SHALL leave acc and cnt unchanged.
REQ-022 Throughput SHALL be one operand pair per cycle.
REQ-023 The handshake that makes cnt=0 SHALL move the FSM to OUT, so out_valid_o rises on the next cycle.
REQ-024 Arithmetic SHALL be full-precision signed at ACC_W bits, with overflow wrapping modulo 2^ACC_W.
REQ-025 y_ori_o SHALL equal acc.
REQ-026 y_sat_o SHALL be (acc >>> SHIFT) clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 sat_o SHALL be 1 iff the REQ-026 clamp was applied.
REQ-028 In OUT: out_valid_o=1, and y_*_o and sat_o SHALL be held stable until out_ready_i=1.
REQ-029 An OUT handshake SHALL return the FSM to IDLE; a start_i in that same cycle SHALL be ignored.
REQ-030 y_ori_o, y_sat_o and sat_o SHALL hold their last values in IDLE.

Reset
REQ-031 rst_ni=0 SHALL immediately force IDLE, acc=0, cnt=0, and busy_o, in_ready_o, out_valid_o, sat_o, y_ori_o and y_sat_o all 0, including mid-job.
REQ-032 Any partial job SHALL be discarded on reset and never output.

Configuration
REQ-033 With DOT_PRODUCT_CTRL_PIPE_EN defined, a register SHALL sit between multiplier and adder, and the last ACCUM handshake SHALL go to DRAIN for one cycle (in_ready_o=0) before OUT, adding one cycle of latency at the same throughput.
REQ-034 Without DOT_PRODUCT_CTRL_PIPE_EN, the design SHALL have no product register and no DRAIN state, with latency per REQ-023.

Structure
REQ-035 Package dot_product_pkg SHALL hold the state_e enum and the default WIDTH/MAXN constants.
REQ-036 Sub-module mul_add_unit (combinational a*x+b, ACC_W result, shift and saturate) SHALL be instantiated once; the FSM, counter and acc register SHALL live in dot_product_ctrl.

Verification
REQ-037 Test: len=3, bias=0, pairs (2,3),(-4,5),(7,1) back-to-back -> y_ori_o=-7, y_sat_o=-7, sat_o=0, with out_valid_o asserted one cycle after the 3rd handshake (two with PIPE_EN).
REQ-038 Test: len=2, pairs (32767,32767) twice -> y_ori_o=2147352578, y_sat_o=32767, sat_o=1; len=1, pair (-32768,32767) -> y_ori_o=-1073709056, y_sat_o=-32768, sat_o=1.
REQ-039 Test: len=0, bias=100 -> OUT the next cycle with y_ori_o=100, y_sat_o=100, no in_ready_o pulse.
REQ-040 Test: len=4 with in_valid_i bubbles on alternate cycles -> exactly 4 pairs accumulated; bubbles change nothing.
REQ-041 Test: out_ready_i=0 for 5 cycles with start_i pulsed -> outputs stable, busy_o=1, start ignored; then out_ready_i=1 -> IDLE next cycle.
REQ-042 Test: rst_ni low after 2 of 4 pairs -> all outputs 0 immediately; a new job len=1 with pair (3,3) -> y_ori_o=9.
